// File: rtl/quick_spi_pkg.sv
// Shared definitions for the quick_spi master/slave family: order constants,
// slave state encoding and the word <-> wire bit mapping.
package quick_spi_pkg;

  localparam int QS_LITTLE_ENDIAN = 0;
  localparam int QS_BIG_ENDIAN    = 1;
  localparam int QS_LSB_FIRST     = 0;
  localparam int QS_MSB_FIRST     = 1;

  typedef enum logic [1:0] {
    QS_IDLE  = 2'd0,
    QS_LOAD  = 2'd1,
    QS_SHIFT = 2'd2
  } qs_slave_state_t;

  // Word bit index carried at wire position pos. Reversing the byte index and
  // the bit-in-byte index are each self-inverse, so the same map serves both
  // word->wire and wire->word.
  function automatic int qs_wire_index(input int pos, input int nbytes,
                                       input int bytes_order, input int bits_order);
    int byte_sel;
    int bit_sel;
    byte_sel = (bytes_order == QS_LITTLE_ENDIAN) ? pos / 8 : nbytes - 1 - pos / 8;
    bit_sel  = (bits_order == QS_LSB_FIRST) ? pos % 8 : 7 - pos % 8;
    return byte_sel * 8 + bit_sel;
  endfunction

endpackage

// File: rtl/quick_spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, with a third register
// for single-cycle rise/fall detection in the clk domain.
module quick_spi_sync #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/quick_spi_slave.sv
// SPI responder oversampling sclk/ss_n/mosi in the clk domain.
// state | meaning: IDLE deselected | LOAD capture tx word | SHIFT exchange bits
module quick_spi_slave
  import quick_spi_pkg::*;
#(
  parameter int DATA_BYTES  = 2,
  parameter int BYTES_ORDER = 0,
  parameter int BITS_ORDER  = 0,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sclk,
  input  logic                    ss_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  input  logic [8*DATA_BYTES-1:0] outgoing_data,
  output logic [8*DATA_BYTES-1:0] incoming_data,
  output logic                    rx_valid,
  output logic                    rx_abort,
  output logic                    busy
);

  localparam int W     = 8 * DATA_BYTES;
  localparam int CNT_W = $clog2(W + 1);

  logic sclk_lvl_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_lvl;
  logic ss_rise;
  logic ss_fall;
  logic mosi_lvl;
  logic mosi_rise_unused;
  logic mosi_fall_unused;

  quick_spi_sync #(.RST_VAL(CPOL != 0)) u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (sclk),
    .q_o     (sclk_lvl_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  quick_spi_sync #(.RST_VAL(1'b1)) u_sync_ss (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (ss_n),
    .q_o     (ss_lvl),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  quick_spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (mosi),
    .q_o     (mosi_lvl),
    .rise_o  (mosi_rise_unused),
    .fall_o  (mosi_fall_unused)
  );

  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;

  assign lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
  assign trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
  assign sample_edge = ((CPHA == 0) ? lead_edge : trail_edge) & ~ss_lvl;
  assign shift_edge  = ((CPHA == 0) ? trail_edge : lead_edge) & ~ss_lvl;

  qs_slave_state_t  state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [W-1:0]     tx_q, tx_d;
  logic [W-2:0]     rx_q, rx_d;
  logic             miso_q, miso_d;
  logic [W-1:0]     incoming_q, incoming_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_abort_q, rx_abort_d;

  logic [W-1:0] tx_load;
  logic [W-1:0] rx_full;
  logic [W-1:0] rx_word;

  // rx_full is in wire order: bit 0 is the first bit received.
  assign rx_full = {mosi_lvl, rx_q};

  for (genvar k = 0; k < W; k++) begin : g_order
    localparam int IDX = qs_wire_index(k, DATA_BYTES, BYTES_ORDER, BITS_ORDER);
    assign tx_load[k] = outgoing_data[IDX];
    assign rx_word[k] = rx_full[IDX];
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    miso_d     = miso_q;
    incoming_d = incoming_q;
    rx_valid_d = 1'b0;
    rx_abort_d = 1'b0;

    unique case (state_q)
      QS_IDLE: begin
        if (ss_fall) state_d = QS_LOAD;
      end
      QS_LOAD: begin
        bit_cnt_d = '0;
        state_d   = QS_SHIFT;
        // Mode 0 presents bit 0 up front, so tx_q then holds the bits still to come.
        if (CPHA == 0) begin
          miso_d = tx_load[0];
          tx_d   = tx_load >> 1;
        end else begin
          miso_d = 1'b0;
          tx_d   = tx_load;
        end
      end
      QS_SHIFT: begin
        if (sample_edge) begin
          rx_d = rx_full[W-1:1];
          if (bit_cnt_q == CNT_W'(W - 1)) begin
            incoming_d = rx_word;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            tx_d       = tx_load;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (shift_edge) begin
          miso_d = tx_q[0];
          tx_d   = tx_q >> 1;
        end
      end
      default: state_d = QS_IDLE;
    endcase

    // A word finishing on the deselect cycle has already cleared bit_cnt_d.
    if (ss_rise) begin
      rx_abort_d = (bit_cnt_d != '0);
      state_d    = QS_IDLE;
      bit_cnt_d  = '0;
      miso_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= QS_IDLE;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      miso_q     <= 1'b0;
      incoming_q <= '0;
      rx_valid_q <= 1'b0;
      rx_abort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      miso_q     <= miso_d;
      incoming_q <= incoming_d;
      rx_valid_q <= rx_valid_d;
      rx_abort_q <= rx_abort_d;
    end
  end

  assign miso          = miso_q;
  assign miso_oe       = (state_q != QS_IDLE);
  assign busy          = (state_q != QS_IDLE);
  assign incoming_data = incoming_q;
  assign rx_valid      = rx_valid_q;
  assign rx_abort      = rx_abort_q;

endmodule

// File: tb/tb_quick_spi_slave.sv
// Bench for quick_spi_slave: two instances (mode 0 LE/LSB-first, mode 3
// BE/MSB-first) driven by a behavioural SPI master.
module tb_quick_spi_slave;

  localparam int H = 8;
  localparam bit [1:0] BO_V   = 2'b10;
  localparam bit [1:0] BI_V   = 2'b10;
  localparam bit [1:0] CPOL_V = 2'b10;
  localparam bit [1:0] CPHA_V = 2'b10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sclk [2];
  logic        ss_n [2];
  logic        mosi [2];
  logic        miso [2];
  logic        miso_oe [2];
  logic [15:0] outgoing [2];
  logic [15:0] incoming [2];
  logic        rx_valid [2];
  logic        rx_abort [2];
  logic        busy [2];

  int          n_checks = 0;
  int          n_errors = 0;
  int          nvalid [2];
  int          nabort [2];
  logic [15:0] rx_last [2];
  logic [15:0] rx_prev [2];

  always #5 clk = ~clk;

  quick_spi_slave u_dut0 (
    .clk           (clk),
    .reset_n       (reset_n),
    .sclk          (sclk[0]),
    .ss_n          (ss_n[0]),
    .mosi          (mosi[0]),
    .miso          (miso[0]),
    .miso_oe       (miso_oe[0]),
    .outgoing_data (outgoing[0]),
    .incoming_data (incoming[0]),
    .rx_valid      (rx_valid[0]),
    .rx_abort      (rx_abort[0]),
    .busy          (busy[0])
  );

  quick_spi_slave #(
    .DATA_BYTES  (2),
    .BYTES_ORDER (1),
    .BITS_ORDER  (1),
    .CPOL        (1),
    .CPHA        (1)
  ) u_dut1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .sclk          (sclk[1]),
    .ss_n          (ss_n[1]),
    .mosi          (mosi[1]),
    .miso          (miso[1]),
    .miso_oe       (miso_oe[1]),
    .outgoing_data (outgoing[1]),
    .incoming_data (incoming[1]),
    .rx_valid      (rx_valid[1]),
    .rx_abort      (rx_abort[1]),
    .busy          (busy[1])
  );

  initial begin
    nvalid = '{0, 0};
    nabort = '{0, 0};
    rx_last = '{16'd0, 16'd0};
    rx_prev = '{16'd0, 16'd0};
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rx_valid[d]) begin
        nvalid[d]  <= nvalid[d] + 1;
        rx_prev[d] <= rx_last[d];
        rx_last[d] <= incoming[d];
      end
      if (rx_abort[d]) nabort[d] <= nabort[d] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Wire sequence of a 16-bit word: bit k of the result is the k-th bit on the wire.
  function automatic logic [15:0] wire_seq(input logic [15:0] w, input int bo, input int bi);
    logic [15:0] s;
    logic [7:0]  byt;
    int          k;
    s = '0;
    k = 0;
    for (int j = 0; j < 2; j++) begin
      byt = (bo == 0) ? w[j*8 +: 8] : w[(1-j)*8 +: 8];
      for (int b = 0; b < 8; b++) begin
        s[k] = (bi == 0) ? byt[b] : byt[7-b];
        k++;
      end
    end
    return s;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_cycle(input int d, input logic b, output logic m);
    if (CPHA_V[d] == 1'b0) begin
      mosi[d] = b;
      wait_clk(H);
      m = miso[d];
      sclk[d] = ~CPOL_V[d];
      wait_clk(H);
      sclk[d] = CPOL_V[d];
    end else begin
      wait_clk(H);
      sclk[d] = ~CPOL_V[d];
      mosi[d] = b;
      wait_clk(H);
      m = miso[d];
      sclk[d] = CPOL_V[d];
    end
  endtask

  task automatic xfer(input int d, input int nbits, input logic [15:0] tx0, input logic [15:0] tx1,
                      input logic [15:0] rx0, input logic [15:0] rx1, output logic [31:0] seen);
    logic [31:0] wire_in;
    logic        m;
    wire_in = {wire_seq(rx1, BO_V[d], BI_V[d]), wire_seq(rx0, BO_V[d], BI_V[d])};
    seen = '0;
    outgoing[d] = tx0;
    ss_n[d] = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == 9) outgoing[d] = tx1;
      bit_cycle(d, wire_in[i], m);
      seen[i] = m;
      if (i == 0) check_eq("busy_oe_active", {30'd0, busy[d], miso_oe[d]}, 32'd3);
    end
    wait_clk(H);
    ss_n[d] = 1'b1;
    wait_clk(H);
    check_eq("idle_after_deselect", {29'd0, busy[d], miso_oe[d], miso[d]}, 32'd0);
  endtask

  task automatic check_word(input int d, input logic [15:0] tx, input logic [15:0] rx, input string tag);
    logic [31:0] seen;
    int          v0;
    int          a0;
    v0 = nvalid[d];
    a0 = nabort[d];
    xfer(d, 16, tx, tx, rx, rx, seen);
    check_eq({tag, "_miso"}, {16'd0, seen[15:0]}, {16'd0, wire_seq(tx, BO_V[d], BI_V[d])});
    check_eq({tag, "_rx"}, {16'd0, incoming[d]}, {16'd0, rx});
    check_eq({tag, "_nvalid"}, nvalid[d] - v0, 32'd1);
    check_eq({tag, "_nabort"}, nabort[d] - a0, 32'd0);
  endtask

  initial begin
    logic [31:0] seen;
    logic [15:0] old;
    logic [15:0] txr;
    logic [15:0] rxr;
    logic        act;
    logic        m;
    int          v0;
    int          a0;

    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sclk[d]     = CPOL_V[d];
      ss_n[d]     = 1'b1;
      mosi[d]     = 1'b0;
      outgoing[d] = '0;
    end
    wait_clk(4);
    for (int d = 0; d < 2; d++)
      check_eq("reset_state", {11'd0, incoming[d], miso[d], miso_oe[d], rx_valid[d], rx_abort[d], busy[d]}, 32'd0);
    reset_n = 1'b1;
    wait_clk(4);

    // Mode 0, little endian, LSB first
    check_word(0, 16'hCC81, 16'h95A3, "le_lsb");

    // Mode 3, big endian, MSB first: CC MSB-first then 81
    v0 = nvalid[1];
    xfer(1, 16, 16'hCC81, 16'hCC81, 16'h1234, 16'h1234, seen);
    check_eq("be_msb_miso", {16'd0, seen[15:0]}, 32'h0000_8133);
    check_eq("be_msb_rx", {16'd0, incoming[1]}, 32'h0000_1234);
    check_eq("be_msb_nvalid", nvalid[1] - v0, 32'd1);

    // Back-to-back words under one select, tx word changed mid first word
    v0 = nvalid[0];
    a0 = nabort[0];
    xfer(0, 32, 16'hA55A, 16'h00FF, 16'h1357, 16'hBEEF, seen);
    check_eq("b2b_nvalid", nvalid[0] - v0, 32'd2);
    check_eq("b2b_nabort", nabort[0] - a0, 32'd0);
    check_eq("b2b_rx_first", {16'd0, rx_prev[0]}, 32'h0000_1357);
    check_eq("b2b_rx_second", {16'd0, rx_last[0]}, 32'h0000_BEEF);
    check_eq("b2b_miso_first", {16'd0, seen[15:0]}, {16'd0, wire_seq(16'hA55A, 0, 0)});
    check_eq("b2b_miso_second", {16'd0, seen[31:16]}, {16'd0, wire_seq(16'h00FF, 0, 0)});

    // Abort after 9 bits
    old = incoming[0];
    v0 = nvalid[0];
    a0 = nabort[0];
    xfer(0, 9, 16'h3C3C, 16'h3C3C, 16'h7E81, 16'h7E81, seen);
    check_eq("abort_nabort", nabort[0] - a0, 32'd1);
    check_eq("abort_nvalid", nvalid[0] - v0, 32'd0);
    check_eq("abort_rx_held", {16'd0, incoming[0]}, {16'd0, old});
    check_word(0, 16'h0F0F, 16'hC001, "after_abort");

    // sclk noise while deselected
    v0 = nvalid[0];
    a0 = nabort[0];
    act = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sclk[0] = ~sclk[0];
      mosi[0] = i[0];
      wait_clk(4);
      act = act | busy[0] | miso_oe[0] | miso[0];
    end
    check_eq("noise_activity", {31'd0, act}, 32'd0);
    check_eq("noise_pulses", (nvalid[0] - v0) + (nabort[0] - a0), 32'd0);

    // Reset in the middle of a transfer
    v0 = nvalid[0];
    a0 = nabort[0];
    outgoing[0] = 16'h5AA5;
    ss_n[0] = 1'b0;
    for (int i = 0; i < 5; i++) bit_cycle(0, i[0], m);
    reset_n = 1'b0;
    #1;
    check_eq("reset_mid_outputs", {11'd0, incoming[0], miso[0], miso_oe[0], rx_valid[0], rx_abort[0], busy[0]}, 32'd0);
    sclk[0] = CPOL_V[0];
    ss_n[0] = 1'b1;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(4);
    check_eq("reset_mid_pulses", (nvalid[0] - v0) + (nabort[0] - a0), 32'd0);
    check_word(0, 16'hE71D, 16'h2468, "after_reset");

    // Randomized single-word transfers on both configurations
    for (int r = 0; r < 6; r++) begin
      for (int d = 0; d < 2; d++) begin
        txr = 16'($urandom);
        rxr = 16'($urandom);
        check_word(d, txr, rxr, "random");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
